dac_axil_regbank: RTL and testbench

Parametrised AXI4-Lite slave register bank for the AD9122 DAC control path. It generalises the fixed four-register control slave to N registers of configurable width, with byte strobes and per-register read-only status mapping. It also provides per-register write-strobe pulses and SLVERR on out-of-range accesses. It sits between the block-design AXI interconnect and the DAC datapath/SPI configuration logic.

---
 rtl/dac_axil_pkg.sv | 25 ++
 rtl/dac_axil_regbank_if.sv | 37 +++
 rtl/dac_axil_wr_join.sv | 108 ++++++++++
 rtl/dac_axil_regbank.sv | 148 ++++++++++++++
 tb/tb_dac_axil_regbank.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_axil_pkg.sv
// Shared types and helpers for the AD9122 DAC AXI4-Lite control register bank.
package dac_axil_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } axil_resp_t;

   // Number of byte-offset address bits below the register index
   function automatic int axil_lsb(input int data_width);
      return $clog2(data_width / 8);
   endfunction

   // Legal parameter set: 32/64-bit bus, 1..256 registers, address space large enough
   function automatic bit axil_params_ok(input int data_width, input int num_regs,
                                         input int addr_width);
      bit ok;
      ok = (data_width == 32 || data_width == 64);
      ok = ok && (num_regs >= 1) && (num_regs <= 256);
      ok = ok && (addr_width > axil_lsb(data_width)) && (addr_width <= 32);
      ok = ok && ((longint'(1) << addr_width) >= longint'(num_regs) * longint'(data_width / 8));
      return ok;
   endfunction

endpackage

// File: rtl/dac_axil_regbank_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the register bank (slave).
interface dac_axil_regbank_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
);
   logic                      AWVALID;
   logic                      AWREADY;
   logic [ADDR_WIDTH-1:0]     AWADDR;
   logic [2:0]                AWPROT;
   logic                      WVALID;
   logic                      WREADY;
   logic [DATA_WIDTH-1:0]     WDATA;
   logic [DATA_WIDTH/8-1:0]   WSTRB;
   logic                      BVALID;
   logic                      BREADY;
   logic [1:0]                BRESP;
   logic                      ARVALID;
   logic                      ARREADY;
   logic [ADDR_WIDTH-1:0]     ARADDR;
   logic [2:0]                ARPROT;
   logic                      RVALID;
   logic                      RREADY;
   logic [DATA_WIDTH-1:0]     RDATA;
   logic [1:0]                RRESP;

   modport master (
      output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
             ARVALID, ARADDR, ARPROT, RREADY,
      input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
   );

   modport slave (
      input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
             ARVALID, ARADDR, ARPROT, RREADY,
      output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
   );
endinterface

// File: rtl/dac_axil_wr_join.sv
// Write-address / write-data join: independent AW and W holds, commit strobe, B channel.
module dac_axil_wr_join
   import dac_axil_pkg::*;
#(
   parameter int  DATA_WIDTH = 32,
   parameter int  ADDR_WIDTH = 12,
   parameter int  NUM_REGS   = 8,
   localparam int LSB        = axil_lsb(DATA_WIDTH),
   localparam int IDX_W      = ADDR_WIDTH - LSB
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_awvalid,
   output logic                    o_awready,
   input  logic [ADDR_WIDTH-1:0]   i_awaddr,
   input  logic                    i_wvalid,
   output logic                    o_wready,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_wstrb,
   output logic                    o_bvalid,
   input  logic                    i_bready,
   output logic [1:0]              o_bresp,
   output logic                    o_commit,
   output logic [IDX_W-1:0]        o_idx,
   output logic [DATA_WIDTH-1:0]   o_wdata,
   output logic [DATA_WIDTH/8-1:0] o_wstrb
);

   logic                    r_aw_held;
   logic                    r_w_held;
   logic                    r_bvalid;
   logic                    r_awready;
   logic                    r_wready;
   axil_resp_t              r_bresp;
   logic [IDX_W-1:0]        r_idx;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [DATA_WIDTH/8-1:0] r_wstrb;

   logic w_aw_hs;
   logic w_w_hs;
   logic w_commit;
   logic w_oor;
   logic w_aw_held_nxt;
   logic w_w_held_nxt;
   logic w_bvalid_nxt;
   logic w_unused;

   assign w_aw_hs  = i_awvalid && r_awready;
   assign w_w_hs   = i_wvalid && r_wready;
   // Commit only once both halves are held and the previous response has drained
   assign w_commit = r_aw_held && r_w_held && !r_bvalid;
   assign w_oor    = 32'(r_idx) >= 32'(NUM_REGS);
   // Byte-offset bits inside a register are don't-care
   assign w_unused = ^i_awaddr[LSB-1:0];

   // Next-state of the holds and the response valid
   always_comb begin
      w_aw_held_nxt = r_aw_held;
      w_w_held_nxt  = r_w_held;
      w_bvalid_nxt  = r_bvalid;
      if (r_bvalid && i_bready) w_bvalid_nxt = 1'b0;
      if (w_aw_hs)              w_aw_held_nxt = 1'b1;
      if (w_w_hs)               w_w_held_nxt  = 1'b1;
      if (w_commit) begin
         w_aw_held_nxt = 1'b0;
         w_w_held_nxt  = 1'b0;
         w_bvalid_nxt  = 1'b1;
      end
   end

   // Control state; READYs are registered from the next-state so no VALID->READY path exists
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bresp   <= OKAY;
      end else begin
         r_aw_held <= w_aw_held_nxt;
         r_w_held  <= w_w_held_nxt;
         r_bvalid  <= w_bvalid_nxt;
         r_awready <= !w_aw_held_nxt && !w_bvalid_nxt;
         r_wready  <= !w_w_held_nxt && !w_bvalid_nxt;
         if (w_commit) r_bresp <= w_oor ? SLVERR : OKAY;
      end
   end

   // Captured address index and write data (payload only, no reset needed)
   always_ff @(posedge i_clk) begin
      if (w_aw_hs) r_idx <= i_awaddr[ADDR_WIDTH-1:LSB];
      if (w_w_hs) begin
         r_wdata <= i_wdata;
         r_wstrb <= i_wstrb;
      end
   end

   assign o_awready = r_awready;
   assign o_wready  = r_wready;
   assign o_bvalid  = r_bvalid;
   assign o_bresp   = r_bresp;
   assign o_commit  = w_commit;
   assign o_idx     = r_idx;
   assign o_wdata   = r_wdata;
   assign o_wstrb   = r_wstrb;

endmodule

// File: rtl/dac_axil_regbank.sv
// AXI4-Lite register bank for the AD9122 DAC control path: N RW/RO registers,
// byte strobes, per-register write pulses and SLVERR on out-of-range accesses.
module dac_axil_regbank
   import dac_axil_pkg::*;
#(
   parameter int                            DATA_WIDTH = 32,
   parameter int                            NUM_REGS   = 8,
   parameter int                            ADDR_WIDTH = 12,
   parameter logic [NUM_REGS-1:0]           RO_MASK    = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                           ACLK,
   input  logic                           ARESET,
   dac_axil_regbank_if.slave              s_axi,
   output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_o,
   output logic [NUM_REGS-1:0]            wr_pulse_o,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i
);

   localparam int LSB   = axil_lsb(DATA_WIDTH);
   localparam int IDX_W = ADDR_WIDTH - LSB;
   localparam int NB    = DATA_WIDTH / 8;

   if (!axil_params_ok(DATA_WIDTH, NUM_REGS, ADDR_WIDTH)) begin : g_bad_params
      $error("dac_axil_regbank: illegal DATA_WIDTH/NUM_REGS/ADDR_WIDTH combination");
   end

   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
   logic [NUM_REGS-1:0]   r_wr_pulse;
   logic                  r_rvalid;
   logic                  r_arready;
   logic [DATA_WIDTH-1:0] r_rdata;
   axil_resp_t            r_rresp;

   logic                  w_awready;
   logic                  w_wready;
   logic                  w_bvalid;
   logic [1:0]            w_bresp;
   logic                  w_commit;
   logic [IDX_W-1:0]      w_idx;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [NB-1:0]         w_wstrb;
   logic [IDX_W-1:0]      w_ar_idx;
   logic                  w_ar_hs;
   logic                  w_rvalid_nxt;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic                  w_rd_oor;
   logic                  w_unused;

   dac_axil_wr_join #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS)
   ) u_wr_join (
      .i_clk     (ACLK),
      .i_rst     (ARESET),
      .i_awvalid (s_axi.AWVALID),
      .o_awready (w_awready),
      .i_awaddr  (s_axi.AWADDR),
      .i_wvalid  (s_axi.WVALID),
      .o_wready  (w_wready),
      .i_wdata   (s_axi.WDATA),
      .i_wstrb   (s_axi.WSTRB),
      .o_bvalid  (w_bvalid),
      .i_bready  (s_axi.BREADY),
      .o_bresp   (w_bresp),
      .o_commit  (w_commit),
      .o_idx     (w_idx),
      .o_wdata   (w_wdata),
      .o_wstrb   (w_wstrb)
   );

   assign s_axi.AWREADY = w_awready;
   assign s_axi.WREADY  = w_wready;
   assign s_axi.BVALID  = w_bvalid;
   assign s_axi.BRESP   = w_bresp;
   assign s_axi.ARREADY = r_arready;
   assign s_axi.RVALID  = r_rvalid;
   assign s_axi.RDATA   = r_rdata;
   assign s_axi.RRESP   = r_rresp;

   // PROT and the byte offset within a register carry no meaning here
   assign w_unused = ^{s_axi.AWPROT, s_axi.ARPROT, s_axi.ARADDR[LSB-1:0]};

   // Register array: byte-strobed commit into RW slots, one-cycle pulse per accepted write
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
         r_wr_pulse <= '0;
      end else begin
         r_wr_pulse <= '0;
         if (w_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if (32'(w_idx) == i && !RO_MASK[i]) begin
                  for (int b = 0; b < NB; b++) begin
                     if (w_wstrb[b]) r_regs[i][b*8 +: 8] <= w_wdata[b*8 +: 8];
                  end
                  r_wr_pulse[i] <= 1'b1;
               end
            end
         end
      end
   end

   // Control outputs: RO slots read as zero on ctrl_o
   always_comb begin
      ctrl_o = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (!RO_MASK[i]) ctrl_o[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
      end
   end

   assign wr_pulse_o = r_wr_pulse;

   // Read source select: RW from the array (pre-commit value), RO from live status
   assign w_ar_idx = s_axi.ARADDR[ADDR_WIDTH-1:LSB];
   always_comb begin
      w_rd_data = '0;
      w_rd_oor  = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (32'(w_ar_idx) == i) begin
            w_rd_oor  = 1'b0;
            w_rd_data = RO_MASK[i] ? status_i[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
         end
      end
   end

   assign w_ar_hs      = s_axi.ARVALID && r_arready;
   assign w_rvalid_nxt = w_ar_hs ? 1'b1 : ((r_rvalid && s_axi.RREADY) ? 1'b0 : r_rvalid);

   // Read channel: single outstanding read, ARREADY registered from next RVALID
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_rvalid  <= 1'b0;
         r_arready <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= OKAY;
      end else begin
         r_rvalid  <= w_rvalid_nxt;
         r_arready <= !w_rvalid_nxt;
         if (w_ar_hs) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_oor ? SLVERR : OKAY;
         end
      end
   end

endmodule

// File: tb/tb_dac_axil_regbank.sv
// Self-checking bench for dac_axil_regbank: directed scenarios plus randomized
// traffic against a byte-level register model.
module tb_dac_axil_regbank;

   localparam int             DW = 32;
   localparam int             NR = 8;
   localparam int             AW = 12;
   localparam logic [NR-1:0]  RO = 8'hC0;
   localparam logic [NR*DW-1:0] RV = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555,
                                      32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dac_axil_regbank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi();

   logic [NR*DW-1:0] ctrl;
   logic [NR-1:0]    pulse;
   logic [NR*DW-1:0] status;
   logic [31:0]      st    [NR];
   logic [31:0]      model [NR];
   int total = 0;
   int bad   = 0;

   always_comb begin
      status = '0;
      for (int i = 0; i < NR; i++) status[i*DW +: DW] = st[i];
   end

   dac_axil_regbank #(
      .DATA_WIDTH (DW),
      .NUM_REGS   (NR),
      .ADDR_WIDTH (AW),
      .RO_MASK    (RO),
      .RESET_VAL  (RV)
   ) dut (
      .ACLK       (clk),
      .ARESET     (rst),
      .s_axi      (axi.slave),
      .ctrl_o     (ctrl),
      .wr_pulse_o (pulse),
      .status_i   (status)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NR; i++) model[i] = RV[i*DW +: DW];
   endtask

   function automatic logic [255:0] exp_ctrl();
      logic [255:0] v;
      v = '0;
      for (int i = 0; i < NR; i++) if (!RO[i]) v[i*DW +: DW] = model[i];
      return v;
   endfunction

   task automatic do_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
      int idx;
      bit aw_done, w_done, aw_hs, w_hs;
      logic [1:0] exp_resp;
      logic [7:0] exp_pulse;
      idx = int'(addr[11:2]);
      exp_resp  = (idx >= NR) ? 2'b10 : 2'b00;
      exp_pulse = '0;
      if (idx < NR && !RO[idx]) exp_pulse[idx] = 1'b1;
      aw_done = 0;
      w_done  = 0;
      for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
         if (!aw_done && c >= aw_dly) begin
            axi.AWVALID = 1'b1; axi.AWADDR = addr; axi.AWPROT = 3'($urandom);
         end
         if (!w_done && c >= w_dly) begin
            axi.WVALID = 1'b1; axi.WDATA = data; axi.WSTRB = strb;
         end
         aw_hs = axi.AWVALID && axi.AWREADY;
         w_hs  = axi.WVALID && axi.WREADY;
         @(posedge clk); #1;
         if (aw_hs) begin aw_done = 1; axi.AWVALID = 1'b0; end
         if (w_hs)  begin w_done  = 1; axi.WVALID  = 1'b0; end
      end
      axi.AWVALID = 1'b0;
      axi.WVALID  = 1'b0;
      check("wr_handshake", {aw_done, w_done}, 2'b11);
      if (!(aw_done && w_done)) return;
      check("bvalid_before_commit", axi.BVALID, 1'b0);
      @(posedge clk); #1;
      if (idx < NR && !RO[idx])
         for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
      check("bvalid_commit", axi.BVALID, 1'b1);
      check("bresp", axi.BRESP, exp_resp);
      check("wr_pulse", pulse, exp_pulse);
      check("ctrl_after_write", ctrl, exp_ctrl());
      for (int c = 0; c < b_dly; c++) begin
         @(posedge clk); #1;
         check("bvalid_hold", axi.BVALID, 1'b1);
         check("bresp_hold", axi.BRESP, exp_resp);
         check("awready_hold", {axi.AWREADY, axi.WREADY}, 2'b00);
         check("pulse_hold", pulse, 8'h00);
      end
      axi.BREADY = 1'b1;
      @(posedge clk); #1;
      axi.BREADY = 1'b0;
      check("bvalid_clear", axi.BVALID, 1'b0);
      check("pulse_clear", pulse, 8'h00);
   endtask

   task automatic do_read(input logic [11:0] addr, input int r_dly, output logic [31:0] rd);
      int idx;
      bit done, hs;
      logic [31:0] ed;
      logic [1:0]  er;
      idx = int'(addr[11:2]);
      if (idx >= NR)   begin ed = '0;         er = 2'b10; end
      else if (RO[idx]) begin ed = st[idx];    er = 2'b00; end
      else             begin ed = model[idx]; er = 2'b00; end
      axi.ARVALID = 1'b1; axi.ARADDR = addr; axi.ARPROT = 3'($urandom);
      done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
         hs = axi.ARVALID && axi.ARREADY;
         @(posedge clk); #1;
         if (hs) done = 1;
      end
      axi.ARVALID = 1'b0;
      check("rd_handshake", done, 1'b1);
      rd = axi.RDATA;
      check("rvalid", axi.RVALID, 1'b1);
      check("rdata", axi.RDATA, ed);
      check("rresp", axi.RRESP, er);
      for (int c = 0; c < r_dly; c++) begin
         @(posedge clk); #1;
         check("rvalid_hold", axi.RVALID, 1'b1);
         check("rdata_hold", axi.RDATA, ed);
         check("arready_hold", axi.ARREADY, 1'b0);
      end
      axi.RREADY = 1'b1;
      @(posedge clk); #1;
      axi.RREADY = 1'b0;
      check("rvalid_clear", axi.RVALID, 1'b0);
      check("arready_back", axi.ARREADY, 1'b1);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] exp0;
      logic [11:0] a;
      int kind;
      axi.AWVALID = 0; axi.AWADDR = '0; axi.AWPROT = '0;
      axi.WVALID  = 0; axi.WDATA  = '0; axi.WSTRB  = '0;
      axi.BREADY  = 0;
      axi.ARVALID = 0; axi.ARADDR = '0; axi.ARPROT = '0;
      axi.RREADY  = 0;
      for (int i = 0; i < NR; i++) st[i] = 32'h0;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_readies", {axi.AWREADY, axi.WREADY, axi.ARREADY}, 3'b000);
      check("rst_valids", {axi.BVALID, axi.RVALID}, 2'b00);
      check("rst_resp_data", {axi.BRESP, axi.RRESP, axi.RDATA}, 36'h0);
      check("rst_pulse", pulse, 8'h00);
      check("rst_ctrl", ctrl, exp_ctrl());
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_readies", {axi.AWREADY, axi.WREADY, axi.ARREADY}, 3'b111);
      check("idle_valids", {axi.BVALID, axi.RVALID}, 2'b00);

      // Same-cycle AW/W full word
      do_write(12'h004, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      check("ctrl_reg1", ctrl[1*DW +: DW], 32'hDEADBEEF);
      do_read(12'h004, 0, rd);
      check("read_reg1", rd, 32'hDEADBEEF);

      // W two cycles ahead of AW, single byte lane
      do_write(12'h008, 32'h11223344, 4'hF, 0, 0, 0);
      do_write(12'h008, 32'h000000AA, 4'b0001, 2, 0, 0);
      check("byte_strobe_reg2", ctrl[2*DW +: DW], 32'h112233AA);
      do_read(12'h00A, 1, rd);
      check("read_reg2", rd, 32'h112233AA);

      // Read-only register
      st[6] = 32'h5A5A0000;
      do_write(12'h018, 32'hFFFFFFFF, 4'hF, 1, 0, 0);
      check("ro_ctrl_zero", ctrl[6*DW +: DW], 32'h0);
      do_read(12'h018, 0, rd);
      check("read_ro6", rd, 32'h5A5A0000);

      // Out of range
      do_write(12'h020, 32'h12345678, 4'hF, 0, 1, 0);
      do_read(12'h020, 0, rd);
      check("read_oor_zero", rd, 32'h0);

      // Back-pressure on B and R
      do_write(12'h00C, 32'hA5A5C3C3, 4'b1010, 0, 0, 5);
      do_read(12'h00C, 5, rd);

      // Randomized traffic
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 7) == 0) st[$urandom_range(6, 7)] = $urandom;
         if ($urandom_range(0, 9) == 0) a = 12'($urandom_range(10, 1023) * 4);
         else a = 12'(($urandom_range(0, 9) * 4) + $urandom_range(0, 3));
         kind = $urandom_range(0, 2);
         if (kind < 2)
            do_write(a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                     $urandom_range(0, 2));
         else
            do_read(a, $urandom_range(0, 2), rd);
      end
      check("ctrl_after_random", ctrl, exp_ctrl());

      // Stall both responses, then reset in the middle of the stall
      exp0 = model[0];
      axi.AWVALID = 1; axi.AWADDR = 12'h004; axi.WVALID = 1;
      axi.WDATA = 32'hCAFEF00D; axi.WSTRB = 4'hF;
      axi.ARVALID = 1; axi.ARADDR = 12'h000;
      @(posedge clk); #1;
      axi.AWVALID = 0; axi.WVALID = 0; axi.ARVALID = 0;
      check("stall_rvalid", axi.RVALID, 1'b1);
      check("stall_rdata", axi.RDATA, exp0);
      @(posedge clk); #1;
      model[1] = 32'hCAFEF00D;
      check("stall_bvalid", axi.BVALID, 1'b1);
      check("stall_pulse", pulse, 8'h02);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check("stall_valids", {axi.BVALID, axi.RVALID}, 2'b11);
         check("stall_readies", {axi.AWREADY, axi.WREADY, axi.ARREADY}, 3'b000);
         check("stall_rdata_hold", axi.RDATA, exp0);
      end
      check("stall_ctrl", ctrl, exp_ctrl());
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check("midrst_valids", {axi.BVALID, axi.RVALID}, 2'b00);
      check("midrst_readies", {axi.AWREADY, axi.WREADY, axi.ARREADY}, 3'b000);
      check("midrst_pulse", pulse, 8'h00);
      check("midrst_ctrl", ctrl, exp_ctrl());
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_readies", {axi.AWREADY, axi.WREADY, axi.ARREADY}, 3'b111);
      check("post_rst_valids", {axi.BVALID, axi.RVALID}, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
